// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS datapath: phase encoding and
// decoder control-code constants.
package mc_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BEQ = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_AND = 2'b11;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MDR = 2'b01;
  localparam logic [1:0] MTR_PC4 = 2'b10;

endpackage

// File: rtl/mc_grf.sv
// General register file: 32 x XLEN, two combinational read ports, one
// synchronous write port; register $0 is hardwired to zero.
module mc_grf #(
  parameter int unsigned XLEN = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0][4:0]      ra,
  output logic [1:0][XLEN-1:0] rd,
  input  logic                 we,
  input  logic [4:0]           wa,
  input  logic [XLEN-1:0]      wd
);

  logic [XLEN-1:0] regs [32];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rport
      assign rd[gi] = (ra[gi] == 5'd0) ? '0 : regs[ra[gi]];
    end
  endgenerate

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle MIPS datapath with FETCH/DECODE/EXEC/MEM/WB sequencing and
// req/ready memory ports. Define GRF_TRACE_EN for simulation write traces.
module mc_datapath
  import mc_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] PC_RESET    = PC_RESET_DEFAULT,
  parameter int unsigned     MEM_LAT_MAX = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      RegDst,
  input  logic            ALUSrc,
  input  logic [1:0]      MemtoReg,
  input  logic            MemWrite,
  input  logic            RegWrite,
  input  logic [1:0]      npcsel,
  input  logic [1:0]      EXTop,
  input  logic [1:0]      ALUctr,
  output logic [XLEN-1:0] instr,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_ready,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ready,
  output logic            instr_done,
  output logic            mem_err
);

  localparam logic [3:0] LAT_LIM = 4'(MEM_LAT_MAX - 1);

  state_t          state_reg;
  logic [XLEN-1:0] pc_reg, pc4_reg, ir_reg, a_reg, b_reg, aluout_reg, mdr_reg;
  logic [3:0]      wait_cnt_reg;
  logic            imem_req_reg, dmem_req_reg, dmem_we_reg;
  logic            instr_done_reg, mem_err_reg;

  logic [4:0]           rs, rt, rd;
  logic [15:0]          imm16;
  logic [25:0]          imm26;
  logic [XLEN-1:0]      ext_out, alu_b, alu_y, next_pc, busw, br_target;
  logic [4:0]           dst;
  logic                 zero, grf_we;
  logic [1:0][XLEN-1:0] grf_rd;

  assign rs    = ir_reg[25:21];
  assign rt    = ir_reg[20:16];
  assign rd    = ir_reg[15:11];
  assign imm16 = ir_reg[15:0];
  assign imm26 = ir_reg[25:0];

  always_comb begin
    ext_out = {{(XLEN-16){1'b0}}, imm16};
    case (EXTop)
      EXT_ZERO: ext_out = {{(XLEN-16){1'b0}}, imm16};
      EXT_SIGN: ext_out = {{(XLEN-16){imm16[15]}}, imm16};
      EXT_LUI:  ext_out = {imm16, {(XLEN-16){1'b0}}};
      default:  ext_out = {{(XLEN-16){1'b0}}, imm16};
    endcase
  end

  assign alu_b = ALUSrc ? ext_out : b_reg;
  assign zero  = (a_reg == alu_b);

  always_comb begin
    alu_y = a_reg + alu_b;
    case (ALUctr)
      ALU_ADD: alu_y = a_reg + alu_b;
      ALU_SUB: alu_y = a_reg - alu_b;
      ALU_OR:  alu_y = a_reg | alu_b;
      ALU_AND: alu_y = a_reg & alu_b;
      default: alu_y = a_reg + alu_b;
    endcase
  end

  // Branch/jump targets are relative to the PC+4 latched during FETCH.
  assign br_target = pc4_reg + {{(XLEN-18){imm16[15]}}, imm16, 2'b00};

  always_comb begin
    next_pc = pc4_reg;
    case (npcsel)
      NPC_PC4: next_pc = pc4_reg;
      NPC_BEQ: next_pc = zero ? br_target : pc4_reg;
      NPC_J:   next_pc = {pc4_reg[XLEN-1:28], imm26, 2'b00};
      NPC_JR:  next_pc = a_reg;
      default: next_pc = pc4_reg;
    endcase
  end

  always_comb begin
    dst = rt;
    case (RegDst)
      DST_RT:  dst = rt;
      DST_RD:  dst = rd;
      DST_RA:  dst = 5'd31;
      default: dst = rt;
    endcase
  end

  always_comb begin
    busw = aluout_reg;
    case (MemtoReg)
      MTR_ALU: busw = aluout_reg;
      MTR_MDR: busw = mdr_reg;
      MTR_PC4: busw = pc4_reg;
      default: busw = aluout_reg;
    endcase
  end

  assign grf_we = (state_reg == WB) && RegWrite;

  mc_grf #(.XLEN(XLEN)) u_grf (
    .clk   (clk),
    .reset (reset),
    .ra    ({rt, rs}),
    .rd    (grf_rd),
    .we    (grf_we),
    .wa    (dst),
    .wd    (busw)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= FETCH;
      pc_reg         <= PC_RESET;
      pc4_reg        <= '0;
      ir_reg         <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      aluout_reg     <= '0;
      mdr_reg        <= '0;
      wait_cnt_reg   <= '0;
      imem_req_reg   <= 1'b0;
      dmem_req_reg   <= 1'b0;
      dmem_we_reg    <= 1'b0;
      instr_done_reg <= 1'b0;
      mem_err_reg    <= 1'b0;
    end else begin
      instr_done_reg <= 1'b0;
      mem_err_reg    <= 1'b0;
      case (state_reg)
        FETCH: begin
          // A low request here means either first fetch after reset or the
          // one-cycle gap after a timeout; either way (re)issue the access.
          if (!imem_req_reg) begin
            imem_req_reg <= 1'b1;
            wait_cnt_reg <= '0;
          end else if (imem_ready) begin
            ir_reg       <= imem_rdata;
            pc4_reg      <= pc_reg + XLEN'(4);
            imem_req_reg <= 1'b0;
            state_reg    <= DECODE;
          end else if (wait_cnt_reg == LAT_LIM) begin
            imem_req_reg <= 1'b0;
            mem_err_reg  <= 1'b1;
            wait_cnt_reg <= '0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 4'd1;
          end
        end
        DECODE: begin
          a_reg     <= grf_rd[0];
          b_reg     <= grf_rd[1];
          state_reg <= EXEC;
        end
        EXEC: begin
          aluout_reg <= alu_y;
          if (MemWrite || MemtoReg == MTR_MDR) begin
            dmem_req_reg <= 1'b1;
            dmem_we_reg  <= MemWrite;
            wait_cnt_reg <= '0;
            state_reg    <= MEM;
          end else if (RegWrite) begin
            state_reg <= WB;
          end else begin
            pc_reg         <= next_pc;
            instr_done_reg <= 1'b1;
            imem_req_reg   <= 1'b1;
            wait_cnt_reg   <= '0;
            state_reg      <= FETCH;
          end
        end
        MEM: begin
          if (!dmem_req_reg) begin
            dmem_req_reg <= 1'b1;
            wait_cnt_reg <= '0;
          end else if (dmem_ready) begin
            mdr_reg      <= dmem_rdata;
            dmem_req_reg <= 1'b0;
            dmem_we_reg  <= 1'b0;
            if (RegWrite) begin
              state_reg <= WB;
            end else begin
              pc_reg         <= next_pc;
              instr_done_reg <= 1'b1;
              imem_req_reg   <= 1'b1;
              wait_cnt_reg   <= '0;
              state_reg      <= FETCH;
            end
          end else if (wait_cnt_reg == LAT_LIM) begin
            dmem_req_reg <= 1'b0;
            mem_err_reg  <= 1'b1;
            wait_cnt_reg <= '0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 4'd1;
          end
        end
        WB: begin
          pc_reg         <= next_pc;
          instr_done_reg <= 1'b1;
          imem_req_reg   <= 1'b1;
          wait_cnt_reg   <= '0;
          state_reg      <= FETCH;
        end
        default: state_reg <= FETCH;
      endcase
    end
  end

  assign instr      = ir_reg;
  assign imem_req   = imem_req_reg;
  assign imem_addr  = pc_reg;
  assign dmem_req   = dmem_req_reg;
  assign dmem_we    = dmem_we_reg;
  assign dmem_addr  = aluout_reg;
  assign dmem_wdata = b_reg;
  assign instr_done = instr_done_reg;
  assign mem_err    = mem_err_reg;

`ifdef GRF_TRACE_EN
  always @(posedge clk) begin
    if (reset && grf_we && dst != 5'd0)
      $display("@%h: $%d <= %h", pc_reg, dst, busw);
    if (reset && state_reg == MEM && dmem_req_reg && dmem_ready && dmem_we_reg)
      $display("@%h: *%h <= %h", pc_reg, aluout_reg, b_reg);
  end
`else
  // Trace output disabled in the default build.
`endif

endmodule
